// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch condition unit:
//   - 4-bit condition-code encodings (COND_EQ .. COND_NV)
//   - bit positions of the individual flags inside status_value
//   - FSM state type used by the top level
// ---------------------------------------------------------------------------
package branch_pkg;

   localparam logic [3:0] COND_EQ = 4'd0;
   localparam logic [3:0] COND_NE = 4'd1;
   localparam logic [3:0] COND_CS = 4'd2;
   localparam logic [3:0] COND_CC = 4'd3;
   localparam logic [3:0] COND_MI = 4'd4;
   localparam logic [3:0] COND_PL = 4'd5;
   localparam logic [3:0] COND_VS = 4'd6;
   localparam logic [3:0] COND_VC = 4'd7;
   localparam logic [3:0] COND_HI = 4'd8;
   localparam logic [3:0] COND_LS = 4'd9;
   localparam logic [3:0] COND_GE = 4'd10;
   localparam logic [3:0] COND_LT = 4'd11;
   localparam logic [3:0] COND_GT = 4'd12;
   localparam logic [3:0] COND_LE = 4'd13;
   localparam logic [3:0] COND_AL = 4'd14;
   localparam logic [3:0] COND_NV = 4'd15;

   localparam int FLAG_V = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_Z = 3;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/condition_evaluator.sv
// ---------------------------------------------------------------------------
// condition_evaluator
// Purely combinational decode of a 4-bit condition code against the flags.
// Ports:
//   flags_i  [3:0]  status flags {Z, N, C, V}
//   cond_i   [3:0]  condition code
//   taken_o         1 when the condition holds
// ---------------------------------------------------------------------------
module condition_evaluator
   import branch_pkg::*;
(
   input  logic [3:0] flags_i,
   input  logic [3:0] cond_i,
   output logic       taken_o
);

   logic flagV;
   logic flagC;
   logic flagN;
   logic flagZ;

   assign flagV = flags_i[FLAG_V];
   assign flagC = flags_i[FLAG_C];
   assign flagN = flags_i[FLAG_N];
   assign flagZ = flags_i[FLAG_Z];

   // Condition table; the signed comparisons use N==V as "greater or equal".
   always_comb begin
      taken_o = 1'b0;
      case (cond_i)
         COND_EQ: taken_o = flagZ;
         COND_NE: taken_o = !flagZ;
         COND_CS: taken_o = flagC;
         COND_CC: taken_o = !flagC;
         COND_MI: taken_o = flagN;
         COND_PL: taken_o = !flagN;
         COND_VS: taken_o = flagV;
         COND_VC: taken_o = !flagV;
         COND_HI: taken_o = flagC & !flagZ;
         COND_LS: taken_o = !flagC | flagZ;
         COND_GE: taken_o = (flagN == flagV);
         COND_LT: taken_o = (flagN != flagV);
         COND_GT: taken_o = !flagZ & (flagN == flagV);
         COND_LE: taken_o = flagZ | (flagN != flagV);
         COND_AL: taken_o = 1'b1;
         COND_NV: taken_o = 1'b0;
         default: taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_condition_unit.sv
// ---------------------------------------------------------------------------
// branch_condition_unit
// Resolves conditional-branch requests against the status flags, holding a
// request while a flag update is in flight (bounded by WAIT_LIMIT cycles),
// and keeps saturating taken / not-taken statistics.
// Ports:
//   clock, reset          clock and asynchronous active-high reset
//   status_value [3:0]    flags {Z, N, C, V}
//   flags_busy            status register is being written this cycle
//   br_valid / br_ready   request handshake (br_ready is combinational)
//   br_cond [3:0]         condition code
//   br_target             branch target
//   pc_load / pc_target   one-cycle PC load pulse and last taken target
//   result_valid          one-cycle pulse per resolved request
//   result_taken          outcome, meaningful with result_valid
//   stall_timeout         resolution was forced by the wait limit
//   clear_counts          synchronous clear of both counters
//   taken_count / not_taken_count   saturating statistics
// ---------------------------------------------------------------------------
module branch_condition_unit
   import branch_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int WAIT_LIMIT = 8,
   parameter int CNT_W      = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [3:0]        status_value,
   input  logic              flags_busy,
   input  logic              br_valid,
   output logic              br_ready,
   input  logic [3:0]        br_cond,
   input  logic [ADDR_W-1:0] br_target,
   output logic              pc_load,
   output logic [ADDR_W-1:0] pc_target,
   output logic              result_valid,
   output logic              result_taken,
   output logic              stall_timeout,
   input  logic              clear_counts,
   output logic [CNT_W-1:0]  taken_count,
   output logic [CNT_W-1:0]  not_taken_count
);

   // A WAIT_LIMIT of 1 still needs a one-bit counter to compare against zero.
   localparam int WCNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
   localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_LIMIT - 1);

   state_t              state_q, state_d;
   logic [3:0]          condHeld_q, condHeld_d;
   logic [ADDR_W-1:0]   targetHeld_q, targetHeld_d;
   logic [WCNT_W-1:0]   waitCnt_q, waitCnt_d;

   logic                pcLoad_q, pcLoad_d;
   logic [ADDR_W-1:0]   pcTarget_q, pcTarget_d;
   logic                resultValid_q, resultValid_d;
   logic                resultTaken_q, resultTaken_d;
   logic                stallTimeout_q, stallTimeout_d;
   logic [CNT_W-1:0]    takenCnt_q, takenCnt_d;
   logic [CNT_W-1:0]    notTakenCnt_q, notTakenCnt_d;

   logic                resolve;
   logic                timeout;
   logic [3:0]          evalCond;
   logic [ADDR_W-1:0]   evalTarget;
   logic                evalTaken;

   assign br_ready = (state_q == IDLE);

   // Single evaluator shared by both states: the live condition is used on an
   // immediate accept, the latched one while waiting for the flags to settle.
   condition_evaluator u_eval (
      .flags_i (status_value),
      .cond_i  (evalCond),
      .taken_o (evalTaken)
   );

   // Next-state logic: accept in IDLE, hold and count in WAIT, and flag the
   // edge on which a request resolves (normally or by timeout).
   always_comb begin
      state_d      = state_q;
      condHeld_d   = condHeld_q;
      targetHeld_d = targetHeld_q;
      waitCnt_d    = waitCnt_q;
      resolve      = 1'b0;
      timeout      = 1'b0;
      evalCond     = br_cond;
      evalTarget   = br_target;
      case (state_q)
         IDLE: begin
            if (br_valid) begin
               if (!flags_busy) begin
                  resolve = 1'b1;
               end else begin
                  state_d      = WAIT;
                  condHeld_d   = br_cond;
                  targetHeld_d = br_target;
                  waitCnt_d    = '0;
               end
            end
         end
         WAIT: begin
            evalCond   = condHeld_q;
            evalTarget = targetHeld_q;
            if (!flags_busy) begin
               resolve = 1'b1;
               state_d = IDLE;
            end else if (waitCnt_q == WAIT_LAST) begin
               resolve = 1'b1;
               timeout = 1'b1;
               state_d = IDLE;
            end else begin
               waitCnt_d = waitCnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output pulses are rebuilt every cycle so they never stretch; the PC
   // target only moves on a taken branch.
   always_comb begin
      pcLoad_d       = 1'b0;
      resultValid_d  = 1'b0;
      stallTimeout_d = 1'b0;
      resultTaken_d  = resultTaken_q;
      pcTarget_d     = pcTarget_q;
      if (resolve) begin
         resultValid_d  = 1'b1;
         resultTaken_d  = evalTaken;
         stallTimeout_d = timeout;
         if (evalTaken) begin
            pcLoad_d   = 1'b1;
            pcTarget_d = evalTarget;
         end
      end
   end

   // Saturating statistics; a clear on the same edge as a resolution wins.
   always_comb begin
      takenCnt_d    = takenCnt_q;
      notTakenCnt_d = notTakenCnt_q;
      if (clear_counts) begin
         takenCnt_d    = '0;
         notTakenCnt_d = '0;
      end else if (resolve) begin
         if (evalTaken) begin
            if (!(&takenCnt_q)) begin
               takenCnt_d = takenCnt_q + 1'b1;
            end
         end else begin
            if (!(&notTakenCnt_q)) begin
               notTakenCnt_d = notTakenCnt_q + 1'b1;
            end
         end
      end
   end

   // All state registers; reset drops any latched request and returns to IDLE.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         condHeld_q     <= '0;
         targetHeld_q   <= '0;
         waitCnt_q      <= '0;
         pcLoad_q       <= 1'b0;
         pcTarget_q     <= '0;
         resultValid_q  <= 1'b0;
         resultTaken_q  <= 1'b0;
         stallTimeout_q <= 1'b0;
         takenCnt_q     <= '0;
         notTakenCnt_q  <= '0;
      end else begin
         state_q        <= state_d;
         condHeld_q     <= condHeld_d;
         targetHeld_q   <= targetHeld_d;
         waitCnt_q      <= waitCnt_d;
         pcLoad_q       <= pcLoad_d;
         pcTarget_q     <= pcTarget_d;
         resultValid_q  <= resultValid_d;
         resultTaken_q  <= resultTaken_d;
         stallTimeout_q <= stallTimeout_d;
         takenCnt_q     <= takenCnt_d;
         notTakenCnt_q  <= notTakenCnt_d;
      end
   end

   assign pc_load         = pcLoad_q;
   assign pc_target       = pcTarget_q;
   assign result_valid    = resultValid_q;
   assign result_taken    = resultTaken_q;
   assign stall_timeout   = stallTimeout_q;
   assign taken_count     = takenCnt_q;
   assign not_taken_count = notTakenCnt_q;

endmodule
